// File: rtl/apb_master_bridge.sv
// Bridges a valid/ready request port onto an APB3 master (SETUP, then ACCESS with wait states),
// with a watchdog that aborts transfers to slaves that never assert pready.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk_apb,
  input  logic              i_rstn_apb,
  input  logic              i_valid,
  input  logic              i_rd0_wr1,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_ready,
  output logic              o_done,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_err,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [ADDR_W-1:0] o_paddr,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic              i_pready,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pslverr
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s, cnt_inc_s;
  logic              capture_s;
  logic              psel_r, psel_nxt_s;
  logic              penable_r, penable_nxt_s;
  logic              pwrite_r;
  logic [ADDR_W-1:0] paddr_r;
  logic [DATA_W-1:0] pwdata_r;
  logic              done_r, done_nxt_s;
  logic              rd_valid_r, rd_valid_nxt_s;
  logic              err_r, err_nxt_s;
  logic [DATA_W-1:0] rd_data_r, rd_data_nxt_s;
  logic              timeout_hit_s;

  // Saturating wait-state count; the abort fires on the edge where it reaches TIMEOUT.
  assign cnt_inc_s     = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
  assign timeout_hit_s = (TIMEOUT != 0) && (cnt_inc_s == CNT_TO);

  // State register
  always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
    if (!i_rstn_apb) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    capture_s      = 1'b0;
    psel_nxt_s     = 1'b0;
    penable_nxt_s  = 1'b0;
    done_nxt_s     = 1'b0;
    rd_valid_nxt_s = 1'b0;
    err_nxt_s      = 1'b0;
    rd_data_nxt_s  = rd_data_r;
    case (state_r)
      ST_IDLE: begin
        if (i_valid) begin
          state_nxt_s = ST_SETUP;
          capture_s   = 1'b1;
          cnt_nxt_s   = {CNT_W{1'b0}};
          psel_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_nxt_s   = ST_ACCESS;
        psel_nxt_s    = 1'b1;
        penable_nxt_s = 1'b1;
      end
      ST_ACCESS: begin
        if (i_pready) begin
          state_nxt_s    = ST_IDLE;
          done_nxt_s     = 1'b1;
          err_nxt_s      = i_pslverr;
          rd_valid_nxt_s = ~pwrite_r;
          if (!pwrite_r) begin
            rd_data_nxt_s = i_pslverr ? {DATA_W{1'b0}} : i_prdata;
          end else begin
            rd_data_nxt_s = rd_data_r;
          end
        end else if (timeout_hit_s) begin
          state_nxt_s    = ST_IDLE;
          cnt_nxt_s      = cnt_inc_s;
          done_nxt_s     = 1'b1;
          err_nxt_s      = 1'b1;
          rd_valid_nxt_s = ~pwrite_r;
          if (!pwrite_r) begin
            rd_data_nxt_s = {DATA_W{1'b0}};
          end else begin
            rd_data_nxt_s = rd_data_r;
          end
        end else begin
          cnt_nxt_s     = cnt_inc_s;
          psel_nxt_s    = 1'b1;
          penable_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Registered APB and requester outputs plus the wait counter
  always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
    if (!i_rstn_apb) begin
      cnt_r      <= {CNT_W{1'b0}};
      psel_r     <= 1'b0;
      penable_r  <= 1'b0;
      pwrite_r   <= 1'b0;
      paddr_r    <= {ADDR_W{1'b0}};
      pwdata_r   <= {DATA_W{1'b0}};
      done_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      err_r      <= 1'b0;
      rd_data_r  <= {DATA_W{1'b0}};
    end else begin
      cnt_r      <= cnt_nxt_s;
      psel_r     <= psel_nxt_s;
      penable_r  <= penable_nxt_s;
      done_r     <= done_nxt_s;
      rd_valid_r <= rd_valid_nxt_s;
      err_r      <= err_nxt_s;
      rd_data_r  <= rd_data_nxt_s;
      if (capture_s) begin
        pwrite_r <= i_rd0_wr1;
        paddr_r  <= i_addr;
        pwdata_r <= i_wr_data;
      end else begin
        pwrite_r <= pwrite_r;
        paddr_r  <= paddr_r;
        pwdata_r <= pwdata_r;
      end
    end
  end

  assign o_ready    = (state_r == ST_IDLE);
  assign o_done     = done_r;
  assign o_rd_valid = rd_valid_r;
  assign o_rd_data  = rd_data_r;
  assign o_err      = err_r;
  assign o_psel     = psel_r;
  assign o_penable  = penable_r;
  assign o_pwrite   = pwrite_r;
  assign o_paddr    = paddr_r;
  assign o_pwdata   = pwdata_r;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: table of single transfers against a scripted
// slave, plus hand sequences for reset during ACCESS and back-to-back requests.
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, rd0_wr1, ready, done, rd_valid, err;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] addr, wdata, rd_data, paddr, pwdata, prdata;

  int checks   = 0;
  int failures = 0;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .i_clk_apb (clk),      .i_rstn_apb(rst_n),
    .i_valid   (valid),    .i_rd0_wr1 (rd0_wr1),
    .i_addr    (addr),     .i_wr_data (wdata),
    .o_ready   (ready),    .o_done    (done),
    .o_rd_valid(rd_valid), .o_rd_data (rd_data),
    .o_err     (err),      .o_psel    (psel),
    .o_penable (penable),  .o_pwrite  (pwrite),
    .o_paddr   (paddr),    .o_pwdata  (pwdata),
    .i_pready  (pready),   .i_prdata  (prdata),
    .i_pslverr (pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;      // wait states before pready; 255 = never
    logic        slverr;
    logic [31:0] prdata;
    int          exp_cycles; // accept edge to o_done cycle
    int          exp_pen;    // cycles with penable high
    logic        exp_err;
    logic        exp_rdv;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  cyc;
    int  pen;
    bit  got_done;
    @(negedge clk);
    valid = 1'b1; rd0_wr1 = v.wr; addr = v.addr; wdata = v.wdata;
    @(negedge clk);
    valid = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0;
    chk($sformatf("v%0d_setup_psel_pen_ready", idx), {61'd0, psel, penable, ready}, 64'h4);
    chk($sformatf("v%0d_setup_paddr", idx), {32'd0, paddr}, {32'd0, v.addr});
    chk($sformatf("v%0d_setup_pwrite", idx), {63'd0, pwrite}, {63'd0, v.wr});
    cyc = 1; pen = 0; got_done = 1'b0;
    while (!got_done && cyc < 40) begin
      if (penable) begin
        pen++;
        chk($sformatf("v%0d_paddr_stable", idx), {32'd0, paddr}, {32'd0, v.addr});
        chk($sformatf("v%0d_pwdata_stable", idx), {32'd0, pwdata}, {32'd0, v.wdata});
        pready  = (pen == v.waits + 1);
        prdata  = pready ? v.prdata : 32'hBAD0_BAD0;
        pslverr = pready ? v.slverr : 1'b1;
      end else begin
        pready = 1'b0; pslverr = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (done) got_done = 1'b1;
    end
    pready = 1'b0; pslverr = 1'b0;
    if (!got_done) begin
      checks++; failures++;
      $display("FAIL v%0d_done_timeout: got no o_done within %0d cycles, required one", idx, cyc);
    end else begin
      chk($sformatf("v%0d_latency", idx), 64'(cyc), 64'(v.exp_cycles));
      chk($sformatf("v%0d_penable_cycles", idx), 64'(pen), 64'(v.exp_pen));
      chk($sformatf("v%0d_err", idx), {63'd0, err}, {63'd0, v.exp_err});
      chk($sformatf("v%0d_rd_valid", idx), {63'd0, rd_valid}, {63'd0, v.exp_rdv});
      chk($sformatf("v%0d_psel_at_done", idx), {62'd0, psel, penable}, 64'd0);
      if (v.exp_rdv) chk($sformatf("v%0d_rd_data", idx), {32'd0, rd_data}, {32'd0, v.exp_rdata});
    end
    @(negedge clk);
    chk($sformatf("v%0d_single_pulse", idx), {61'd0, done, rd_valid, err}, 64'd0);
  endtask

  initial begin
    int   n_done;
    logic [31:0] setup_addr;
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0,   1'b0, 32'h0,         3,  1,  1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0024, 32'h0,         4,   1'b0, 32'h1234_5678, 7,  5,  1'b0, 1'b1, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h0000_0030, 32'h0,         0,   1'b1, 32'hFFFF_FFFF, 3,  1,  1'b1, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_0040, 32'h0BAD_F00D, 2,   1'b1, 32'h0,         5,  3,  1'b1, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0050, 32'h0,         255, 1'b0, 32'h0,         18, 16, 1'b1, 1'b1, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_0060, 32'h0,         1,   1'b0, 32'hA5A5_A5A5, 4,  2,  1'b0, 1'b1, 32'hA5A5_A5A5};
    vecs[6] = '{1'b1, 32'h0000_0070, 32'h1357_9BDF, 15,  1'b0, 32'h0,         18, 16, 1'b0, 1'b0, 32'h0};

    rst_n = 1'b0; valid = 1'b0; rd0_wr1 = 1'b0; addr = 32'h0; wdata = 32'h0;
    pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {63'd0, ready}, 64'd1);
    chk("reset_ctrl_outs", {58'd0, done, rd_valid, err, psel, penable, pwrite}, 64'd0);
    chk("reset_data_outs", {paddr, pwdata | rd_data}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset asserted between edges during ACCESS
    @(negedge clk); valid = 1'b1; rd0_wr1 = 1'b0; addr = 32'h0000_0080;
    @(negedge clk); valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_access", {62'd0, psel, penable}, 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_async_drop", {62'd0, psel, penable}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    n_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("rst_mid_no_done", 64'(n_done), 64'd0);
    chk("rst_mid_ready", {63'd0, ready}, 64'd1);

    // Continuous valid with a zero-wait slave: one transfer every 3 cycles
    pready = 1'b1; prdata = 32'h0; pslverr = 1'b0;
    valid = 1'b1; rd0_wr1 = 1'b1; addr = 32'h0000_1000; wdata = ~32'h0000_1000;
    n_done = 0; setup_addr = 32'h0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) n_done++;
      if (psel && !penable) begin
        chk("b2b_setup_paddr", {32'd0, paddr}, {32'd0, addr});
        setup_addr = addr;
      end else if (psel && penable) begin
        chk("b2b_access_paddr", {32'd0, paddr}, {32'd0, setup_addr});
        chk("b2b_access_pwdata", {32'd0, pwdata}, {32'd0, ~setup_addr});
      end
      addr  = 32'h0000_1000 + 32'(i * 4);
      wdata = ~addr;
    end
    chk("b2b_done_count", 64'(n_done), 64'd10);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    pready = 1'b0;
    chk("b2b_idle_after_drain", {62'd0, ready, psel}, 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $fatal(1);
  end

endmodule
